// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back/write-allocate cache controller with tree-pLRU
// replacement and full-cache flush; tag/data/state storage is held internally.
module cache_ctrl_nway #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned SETS           = 16,
    parameter int unsigned WAYS           = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cpu_valid_i,
    input  logic                             cpu_we_i,
    input  logic [ADDR_W-1:0]                cpu_addr_i,
    input  logic [WORD_W-1:0]                cpu_wdata_i,
    input  logic [WORD_W/8-1:0]              cpu_be_i,
    output logic [WORD_W-1:0]                cpu_rdata_o,
    output logic                             cpu_ready_o,
    input  logic                             flush_i,
    output logic                             flush_done_o,
    output logic                             mem_valid_o,
    output logic                             mem_we_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic [WORD_W*WORDS_PER_LINE-1:0] mem_wdata_o,
    input  logic                             mem_ready_i,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata_i,
    output logic                             busy_o
);

    localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int unsigned BE_W   = WORD_W / 8;
    localparam int unsigned BYTE_W = $clog2(BE_W);
    localparam int unsigned WOFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFF_W  = WOFF_W + BYTE_W;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned FL_W   = IDX_W + WAY_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_FL_SCAN, S_FL_WB, S_FL_DONE
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-1:0]   plru_q  [SETS];   // heap-ordered tree, bit 0 unused

    logic [WAY_W-1:0] victim_q, victim_d;
    logic [FL_W-1:0]  fl_idx_q, fl_idx_d;

    // Walk the tree from the root; a 0 node selects the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] tree);
        int unsigned node;
        node = 1;
        for (int l = 0; l < int'(WAY_W); l++) begin
            node = 2 * node + 32'(1'(tree >> node));
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Point every node on the accessed path away from the accessed way.
    function automatic logic [WAYS-1:0] plru_update(input logic [WAYS-1:0] tree,
                                                    input logic [WAY_W-1:0] way);
        logic [WAYS-1:0] res;
        int unsigned     node;
        logic            b;
        res  = tree;
        node = 1;
        for (int l = int'(WAY_W) - 1; l >= 0; l--) begin
            b    = 1'(way >> l);
            res  = (res & ~(WAYS'(1) << node)) | (WAYS'(!b) << node);
            node = 2 * node + 32'(b);
        end
        return res;
    endfunction

    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [WOFF_W-1:0] cpu_word;
    logic              unused_addr;

    assign cpu_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_idx     = cpu_addr_i[OFF_W +: IDX_W];
    assign cpu_word    = cpu_addr_i[BYTE_W +: WOFF_W];
    assign unused_addr = ^cpu_addr_i[BYTE_W-1:0];

    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic [WAY_W-1:0]  hit_way, inv_way, miss_victim;
    logic              inv_found;
    logic [LINE_W-1:0] hit_line, merged_line;
    logic [WORD_W-1:0] hit_word, be_mask, new_word;
    int unsigned       word_sh;

    // Tag lookup, victim choice and byte-merged write line for the current request.
    always_comb begin
        hit_vec   = '0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        be_mask   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            hit_vec[w] = valid_q[cpu_idx][w] && (tag_q[cpu_idx][w] == cpu_tag);
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[cpu_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        miss_victim = inv_found ? inv_way : plru_victim(plru_q[cpu_idx]);
        for (int b = 0; b < int'(BE_W); b++) begin
            be_mask[b*8 +: 8] = {8{cpu_be_i[b]}};
        end
        word_sh     = 32'(cpu_word) * WORD_W;
        hit_line    = data_q[cpu_idx][hit_way];
        hit_word    = WORD_W'(hit_line >> word_sh);
        new_word    = (hit_word & ~be_mask) | (cpu_wdata_i & be_mask);
        merged_line = (hit_line & ~(LINE_W'({WORD_W{1'b1}}) << word_sh))
                    | (LINE_W'(new_word) << word_sh);
    end

    assign hit = |hit_vec;

    logic [IDX_W-1:0] fl_set;
    logic [WAY_W-1:0] fl_way;
    logic             fl_last;

    assign fl_set  = fl_idx_q[FL_W-1 -: IDX_W];
    assign fl_way  = fl_idx_q[WAY_W-1:0];
    assign fl_last = (fl_idx_q == FL_W'(SETS * WAYS - 1));

    logic lookup_hit, fill_done, flwb_done;

    assign lookup_hit = (state_q == S_COMPARE) && hit;
    assign fill_done  = (state_q == S_ALLOCATE) && mem_ready_i;
    assign flwb_done  = (state_q == S_FL_WB) && mem_ready_i;

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        fl_idx_d     = fl_idx_q;
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        flush_done_o = 1'b0;
        mem_valid_o  = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    fl_idx_d = '0;
                    state_d  = S_FL_SCAN;
                end else if (cpu_valid_i) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = hit_word;
                    state_d     = S_IDLE;
                end else begin
                    victim_d = miss_victim;
                    state_d  = (valid_q[cpu_idx][miss_victim] && dirty_q[cpu_idx][miss_victim])
                             ? S_WRITE_BACK : S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[cpu_idx][victim_q], cpu_idx, OFF_W'(0)};
                mem_wdata_o = data_q[cpu_idx][victim_q];
                if (mem_ready_i) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = {cpu_tag, cpu_idx, OFF_W'(0)};
                if (mem_ready_i) state_d = S_COMPARE;
            end
            S_FL_SCAN: begin
                if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
                    state_d = S_FL_WB;
                end else if (fl_last) begin
                    state_d = S_FL_DONE;
                end else begin
                    fl_idx_d = fl_idx_q + FL_W'(1);
                end
            end
            S_FL_WB: begin
                mem_valid_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[fl_set][fl_way], fl_set, OFF_W'(0)};
                mem_wdata_o = data_q[fl_set][fl_way];
                if (mem_ready_i) begin
                    if (fl_last) begin
                        state_d = S_FL_DONE;
                    end else begin
                        fl_idx_d = fl_idx_q + FL_W'(1);
                        state_d  = S_FL_SCAN;
                    end
                end
            end
            S_FL_DONE: begin
                flush_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            fl_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            fl_idx_q <= fl_idx_d;
        end
    end

    // Line state: valid/dirty/pLRU.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (lookup_hit) begin
                plru_q[cpu_idx] <= plru_update(plru_q[cpu_idx], hit_way);
                if (cpu_we_i) dirty_q[cpu_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[cpu_idx][victim_q] <= 1'b1;
                dirty_q[cpu_idx][victim_q] <= 1'b0;
            end
            if (flwb_done) dirty_q[fl_set][fl_way] <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (lookup_hit && cpu_we_i) data_q[cpu_idx][hit_way] <= merged_line;
        if (fill_done) begin
            data_q[cpu_idx][victim_q] <= mem_rdata_i;
            tag_q[cpu_idx][victim_q]  <= cpu_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Randomized bench for cache_ctrl_nway: a flat-memory view of the CPU plus an LRU
// cache model predicts read data and every line transaction on the memory port.
module tb_cache_ctrl_nway;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WPL    = 4;
    localparam int unsigned SETS   = 4;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned LINE_W = WORD_W * WPL;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              cpu_valid_i = 1'b0, cpu_we_i = 1'b0;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [WORD_W-1:0] cpu_wdata_i = '0;
    logic [3:0]        cpu_be_i = '0;
    logic [WORD_W-1:0] cpu_rdata_o;
    logic              cpu_ready_o, flush_i = 1'b0, flush_done_o;
    logic              mem_valid_o, mem_we_o, mem_ready_i = 1'b0, busy_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o, mem_rdata_i = '0;

    cache_ctrl_nway #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_valid_i(cpu_valid_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_ready_o(cpu_ready_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];

    logic [WORD_W-1:0] flat    [int unsigned];
    logic [LINE_W-1:0] backing [int unsigned];
    int                stall_force = 0;

    // Initial memory image; line 0x40 holds 0x11111111..0x44444444.
    function automatic logic [WORD_W-1:0] init_word(input int unsigned a);
        if ((a >> 4) == 4) return 32'h11111111 * (((a >> 2) & 3) + 1);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    function automatic logic [WORD_W-1:0] flat_word(input int unsigned a);
        if (flat.exists(a)) return flat[a];
        return init_word(a);
    endfunction

    function automatic logic [LINE_W-1:0] flat_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < int'(WPL); w++) l[w*WORD_W +: WORD_W] = flat_word(la + 4 * w);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] backing_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < int'(WPL); w++) l[w*WORD_W +: WORD_W] = init_word(la + 4 * w);
        return l;
    endfunction

    // Cache model: 2-way tree-pLRU behaves as true LRU, so track the MRU way per set.
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_mru   [SETS];

    task automatic model_reset();
        for (int s = 0; s < int'(SETS); s++) begin
            m_mru[s] = 0;
            for (int w = 0; w < int'(WAYS); w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    task automatic model_access(input bit we, input int unsigned a, input logic [31:0] d,
                                input logic [3:0] be, output bit hit);
        int unsigned s, tag, la;
        int way;
        logic [31:0] wv;
        s   = (a >> 4) & 3;
        tag = a >> 6;
        way = -1;
        for (int w = 0; w < int'(WAYS); w++) if (m_valid[s][w] && m_tag[s][w] == tag) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = 0; w < int'(WAYS); w++) if (!m_valid[s][w] && way < 0) way = w;
            if (way < 0) way = 1 - m_mru[s];
            if (m_valid[s][way] && m_dirty[s][way]) begin
                la = (m_tag[s][way] << 6) | (s << 4);
                exp_q.push_back('{1'b1, ADDR_W'(la), flat_line(la)});
            end
            exp_q.push_back('{1'b0, ADDR_W'(a & 32'hFFF0), '0});
            m_valid[s][way] = 1;
            m_dirty[s][way] = 0;
            m_tag[s][way]   = tag;
        end
        m_mru[s] = way;
        if (we) begin
            m_dirty[s][way] = 1;
            wv = flat_word(a);
            for (int b = 0; b < 4; b++) if (be[b]) wv[b*8 +: 8] = d[b*8 +: 8];
            flat[a] = wv;
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < int'(SETS); s++)
            for (int w = 0; w < int'(WAYS); w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    exp_q.push_back('{1'b1, ADDR_W'((m_tag[s][w] << 6) | (s << 4)),
                                      flat_line((m_tag[s][w] << 6) | (s << 4))});
                    m_dirty[s][w] = 0;
                end
    endtask

    // Memory responder with random latency; also checks mem_* hold steady while stalled.
    initial begin : responder
        bit   active;
        int   wait_cnt;
        txn_t cur;
        active   = 0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ready_i = 1'b0;
            if (rst_i || !mem_valid_o) begin
                active = 0;
            end else begin
                if (!active) begin
                    active   = 1;
                    cur.we   = mem_we_o;
                    cur.addr = mem_addr_o;
                    cur.data = mem_we_o ? mem_wdata_o : '0;
                    wait_cnt = (stall_force > 0) ? stall_force : int'($urandom_range(0, 3));
                end else begin
                    check("mem_we_stable", LINE_W'(mem_we_o), LINE_W'(cur.we));
                    check("mem_addr_stable", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
                    if (cur.we) check("mem_wdata_stable", mem_wdata_o, cur.data);
                end
                if (wait_cnt == 0) begin
                    mem_ready_i = 1'b1;
                    if (cur.we) backing[cur.addr] = cur.data;
                    else        mem_rdata_i = backing_line(cur.addr);
                    obs_q.push_back(cur);
                    active = 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic compare_txns(input string tag);
        check({tag, "_txn_count"}, LINE_W'(obs_q.size()), LINE_W'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_txn_we"}, LINE_W'(obs_q[i].we), LINE_W'(exp_q[i].we));
            check({tag, "_txn_addr"}, LINE_W'(obs_q[i].addr), LINE_W'(exp_q[i].addr));
            check({tag, "_txn_data"}, obs_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic do_access(input bit we, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] be, input bit with_flush,
                             output logic [31:0] rd);
        bit          hit, done;
        logic [31:0] exp_rd;
        int          lat;
        obs_q.delete();
        exp_q.delete();
        if (with_flush) model_flush();
        exp_rd = flat_word(a);
        model_access(we, a, d, be, hit);
        cpu_we_i    = we;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        cpu_be_i    = be;
        cpu_valid_i = 1'b1;
        flush_i     = with_flush;
        rd          = '0;
        if (with_flush) begin
            done = 0;
            lat  = 0;
            while (!done && lat < 400) begin
                @(negedge clk);
                lat++;
                flush_i = 1'b0;
                if (cpu_ready_o) check("ready_during_flush", 1, 0);
                if (flush_done_o) done = 1;
            end
            if (!done) check("flush_timeout", 0, 1);
        end
        done = 0;
        lat  = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (cpu_ready_o) done = 1;
        end
        if (!done) begin
            check("ready_timeout", 0, 1);
            cpu_valid_i = 1'b0;
            return;
        end
        rd          = cpu_rdata_o;
        cpu_valid_i = 1'b0;
        if (!we) check("rdata", LINE_W'(rd), LINE_W'(exp_rd));
        if (hit && !with_flush) check("hit_latency", LINE_W'(lat + 1), 2);
        @(negedge clk);
        check("ready_pulse", LINE_W'(cpu_ready_o), 0);
        check("idle_after_access", LINE_W'(busy_o), 0);
        compare_txns(with_flush ? "flush_access" : "access");
    endtask

    task automatic do_flush();
        bit clean, done;
        int lat;
        obs_q.delete();
        exp_q.delete();
        model_flush();
        clean   = (exp_q.size() == 0);
        flush_i = 1'b1;
        done    = 0;
        lat     = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            flush_i = 1'b0;
            if (cpu_ready_o) check("ready_in_flush", 1, 0);
            if (flush_done_o) done = 1;
        end
        if (!done) check("flush_timeout", 0, 1);
        if (clean && done) check("flush_cycles", LINE_W'(lat), LINE_W'(SETS * WAYS + 1));
        @(negedge clk);
        check("flush_done_pulse", LINE_W'(flush_done_o), 0);
        check("idle_after_flush", LINE_W'(busy_o), 0);
        compare_txns("flush");
    endtask

    logic [31:0] rd;
    bit          got_alloc;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check("rst_busy", LINE_W'(busy_o), 0);
        check("rst_ready", LINE_W'(cpu_ready_o), 0);
        check("rst_rdata", LINE_W'(cpu_rdata_o), 0);
        check("rst_mem_valid", LINE_W'(mem_valid_o), 0);
        check("rst_mem_we", LINE_W'(mem_we_o), 0);
        check("rst_mem_addr", LINE_W'(mem_addr_o), 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_flush_done", LINE_W'(flush_done_o), 0);

        // Read miss after reset, then byte-merged write hit.
        do_access(0, 16'h0044, '0, '0, 0, rd);
        check("t1_rdata", LINE_W'(rd), LINE_W'(32'h22222222));
        check("t1_fill_only", LINE_W'(obs_q.size()), 1);
        do_access(1, 16'h0044, 32'hAABBCCDD, 4'b0101, 0, rd);
        check("t2_no_traffic", LINE_W'(obs_q.size()), 0);
        do_access(0, 16'h0044, '0, '0, 0, rd);
        check("t2_merged", LINE_W'(rd), LINE_W'(32'h22BB22DD));

        // Replacement order within set 0.
        do_access(0, 16'h0080, '0, '0, 0, rd);
        do_access(0, 16'h0040, '0, '0, 0, rd);
        do_access(0, 16'h00C0, '0, '0, 0, rd);
        check("t3_clean_evict", LINE_W'(obs_q.size()), 1);
        do_access(0, 16'h0080, '0, '0, 0, rd);
        check("t3_wb_then_fill", LINE_W'(obs_q.size()), 2);
        if (obs_q.size() > 0) begin
            check("t3_wb_addr", LINE_W'(obs_q[0].addr), LINE_W'(16'h0040));
            check("t3_wb_word1", LINE_W'(obs_q[0].data[63:32]), LINE_W'(32'h22BB22DD));
        end

        // Flush with a single dirty line, then a clean flush.
        do_access(1, 16'h0084, 32'h0BADF00D, 4'b1111, 0, rd);
        do_flush();
        check("t4_one_wb", LINE_W'(obs_q.size()), 1);
        do_access(0, 16'h0084, '0, '0, 0, rd);
        check("t4_rehit", LINE_W'(obs_q.size()), 0);
        do_flush();

        // Flush and CPU read arriving together.
        do_access(1, 16'h0094, 32'h12345678, 4'b1100, 0, rd);
        do_access(0, 16'h00C4, '0, '0, 1, rd);

        // Long memory stall, then reset in the middle of a fill.
        do_flush();
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        stall_force = 1000;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 16'h0044;
        cpu_valid_i = 1'b1;
        got_alloc   = 0;
        for (int c = 0; c < 10 && !got_alloc; c++) begin
            @(negedge clk);
            if (mem_valid_o) got_alloc = 1;
        end
        check("t5_alloc_seen", LINE_W'(got_alloc), 1);
        for (int c = 0; c < 20; c++) begin
            check("t5_stall_valid", LINE_W'(mem_valid_o), 1);
            check("t5_stall_addr", LINE_W'(mem_addr_o), LINE_W'(16'h0040));
            @(negedge clk);
        end
        rst_i = 1'b1;
        @(negedge clk);
        check("t5_rst_mem_valid", LINE_W'(mem_valid_o), 0);
        check("t5_rst_busy", LINE_W'(busy_o), 0);
        rst_i       = 1'b0;
        cpu_valid_i = 1'b0;
        stall_force = 0;
        @(negedge clk);
        do_access(0, 16'h0044, '0, '0, 0, rd);
        check("t5_miss_again", LINE_W'(obs_q.size()), 1);

        // Random traffic over a few tags per set.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = 16'(($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 4) |
                    ($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 19) == 0) do_flush();
            else do_access(bit'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                           ($urandom_range(0, 24) == 0), rd);
        end

        // After a final flush memory must match the CPU's view.
        do_flush();
        foreach (flat[a]) begin
            logic [LINE_W-1:0] l;
            l = backing_line(a & 32'hFFF0);
            check("coherent", LINE_W'(l[((a >> 2) & 3) * 32 +: 32]), LINE_W'(flat[a]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
